// File: rtl/imm_decode_stage.sv
// RV32 immediate decode stage: decodes on the input side into a 2-entry (main + skid) buffer.
// Define IMM_DECODE_CSR_EN to decode select 5 as a zero-extended CSR zimm; otherwise select 5 is reserved.
module imm_decode_stage #(
  parameter int unsigned N = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [2:0]    in_imm_sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_imm,
  output logic [31:0]   out_instr,
  output logic          out_err
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  typedef struct packed {
    logic [N-1:0] imm;
    logic [31:0]  instr;
    logic         err;
  } beat_t;

  state_t state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  skid_q, skid_d;
  logic   out_valid_q;
  logic   in_ready_q;
  beat_t  dec;
  logic   in_fire;
  logic   out_fire;

  // Every format sign-extends from bit 31; zimm has bit 31 clear, so one extension covers all.
  function automatic beat_t decode(input logic [31:0] instr, input logic [2:0] sel);
    logic [31:0] imm32;
    logic        err;
    beat_t       b;
    imm32 = '0;
    err   = 1'b0;
    case (sel)
      3'd0: imm32 = {{20{instr[31]}}, instr[31:20]};
      3'd1: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'd2: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'd3: imm32 = {instr[31:12], 12'b0};
      3'd4: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_DECODE_CSR_EN
      3'd5: imm32 = {27'b0, instr[19:15]};
`endif
      default: begin
        imm32 = '0;
        err   = 1'b1;
      end
    endcase
    b.imm   = N'($signed(imm32));
    b.instr = instr;
    b.err   = err;
    return b;
  endfunction

  assign dec      = decode(in_instr, in_imm_sel);
  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          main_d  = dec;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && !out_fire) begin
          skid_d  = dec;
          state_d = S_FULL;
        end else if (out_fire && !in_fire) begin
          state_d = S_EMPTY;
        end else if (in_fire && out_fire) begin
          main_d  = dec;
        end
      end
      S_FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != S_EMPTY);
      in_ready_q  <= (state_d != S_FULL);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm   = main_q.imm;
  assign out_instr = main_q.instr;
  assign out_err   = main_q.err;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed-vector bench for imm_decode_stage (N=32 and N=64 instances on shared inputs).
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_sel;
  logic        out_ready;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_imm, out_instr;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [31:0] out_instr64;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.N(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_imm_sel(in_imm_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_instr(out_instr), .out_err(out_err)
  );

  imm_decode_stage #(.N(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_imm_sel(in_imm_sel),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_instr(out_instr64), .out_err(out_err64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One beat through an otherwise idle stage; checked one cycle after acceptance.
  task automatic push_check(input string tag, input logic [31:0] instr, input logic [2:0] sel,
                            input logic [31:0] exp32, input logic [63:0] exp64, input logic exp_err);
    @(negedge clk);
    in_valid = 1'b1; in_instr = instr; in_imm_sel = sel; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_imm"},   64'(out_imm), 64'(exp32));
    chk({tag, "_imm64"}, out_imm64, exp64);
    chk({tag, "_instr"}, 64'(out_instr), 64'(instr));
    chk({tag, "_err"},   64'(out_err), 64'(exp_err));
    chk({tag, "_err64"}, 64'(out_err64), 64'(exp_err));
  endtask

  task automatic present(input logic [31:0] instr);
    in_valid = 1'b1; in_instr = instr; in_imm_sel = 3'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready), 64'd1);
    chk({tag, "_out_imm"},   64'(out_imm), 64'd0);
    chk({tag, "_out_instr"}, 64'(out_instr), 64'd0);
    chk({tag, "_out_err"},   64'(out_err), 64'd0);
    chk({tag, "_out_imm64"}, out_imm64, 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_imm_sel = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    push_check("I",  32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    push_check("S",  32'h0020A423, 3'd1, 32'h00000008, 64'h0000000000000008, 1'b0);
    push_check("B",  32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    push_check("U",  32'h123450B7, 3'd3, 32'h12345000, 64'h0000000012345000, 1'b0);
    push_check("J",  32'h0080006F, 3'd4, 32'h00000008, 64'h0000000000000008, 1'b0);
    push_check("U64", 32'h800000B7, 3'd3, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
`ifdef IMM_DECODE_CSR_EN
    push_check("zimm", 32'h000FD073, 3'd5, 32'h0000001F, 64'h000000000000001F, 1'b0);
`else
    push_check("zimm", 32'h000FD073, 3'd5, 32'h00000000, 64'h0000000000000000, 1'b1);
`endif
    push_check("sel7", 32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1);
    push_check("sel6", 32'h000FD073, 3'd6, 32'h00000000, 64'h0000000000000000, 1'b1);

    // Backpressure: A, B accepted, C stalled until the sink drains.
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_valid", 64'(out_valid), 64'd0);
    present(32'h00100013);
    @(negedge clk);
    chk("bp_ready_after_A", 64'(in_ready), 64'd1);
    present(32'h00200013);
    @(negedge clk);
    chk("bp_ready_after_B", 64'(in_ready), 64'd0);
    chk("bp_head_A", 64'(out_imm), 64'd1);
    present(32'h00300013);
    @(negedge clk);
    chk("bp_ready_stall", 64'(in_ready), 64'd0);
    chk("bp_hold_imm", 64'(out_imm), 64'd1);
    chk("bp_hold_instr", 64'(out_instr), 64'h00100013);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_head_B", 64'(out_imm), 64'd2);
    chk("bp_ready_reopen", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_head_C", 64'(out_imm), 64'd3);
    chk("bp_C_instr", 64'(out_instr), 64'h00300013);
    chk("bp_C_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Flush from FULL, with a beat presented in the flush cycle.
    out_ready = 1'b0;
    present(32'h00400013);
    @(negedge clk);
    present(32'h00500013);
    @(negedge clk);
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    present(32'h00600013);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("fl_dropped", 64'(out_valid), 64'd0);

    // Reset from FULL.
    present(32'hFFF00093);
    @(negedge clk);
    present(32'h00700013);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rs_full", 64'(in_ready), 64'd0);
    chk("rs_head", 64'(out_imm), 64'hFFFFFFFF);
    rst = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    check_reset_outputs("rs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
